pipe_ctrl: RTL
==============

# pipe_ctrl

Central stall/flush controller for the dual-issue pipeline. It drives the hold and clear controls of the five inter-stage registers (if_id, id_is, is_ex, ex_mem, mem_wb) from hazard, multi-cycle, cache-wait, branch-redirect and exception events. It owns the multi-cycle EX occupancy counter and the fetch-redirect request. Each pipeline register applies flush over stall.

## Interface
Parameters:
- MC_LAT, 33: cycles a multi-cycle EX op (div) occupies EX; legal range 2..63.
- EXC_VECTOR, 32'hBFC0_0380: fetch target on exception.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load_use  in  1  IS detects a load-use hazard against EX
- ex_multi_start  in  1  multi-cycle op entering execution in EX this cycle
- mem_wait  in  1  MEM stage waiting on D-cache/bus
- br_redirect  in  1  EX resolved a mispredicted branch; level, held while the branch sits in EX
- br_target  in  32  redirect PC, valid with br_redirect
- exc_req  in  1  MEM commits an exception
- stall  out  5  per-register hold; bit0=if_id … bit4=mem_wb
- flush  out  5  per-register clear, same bit order
- fetch_redirect  out  1  one-cycle PC load request to IF
- fetch_pc  out  32  PC for fetch_redirect
- multi_abort  out  1  pulse: kill the running multi-cycle unit
- perf_stall_cnt  out  32  stall-cycle counter (see Configuration)

## Operation
- FSM states: RUN, MULTI, EXC. Down-counter cnt is 6 bits wide.
- All outputs are combinational from state, cnt and inputs. State, cnt and the perf counter are registered.
- Event priority, highest first: exc_req, mem_wait, MULTI-busy, br_redirect, load_use. Only the winning event drives stall/flush in a cycle.
- exc_req (RUN or MULTI):
  - flush=5'b11111, stall=0.
  - fetch_redirect=1, fetch_pc=EXC_VECTOR.
  - If state is MULTI or ex_multi_start=1: multi_abort=1, cnt cleared.
  - Next state EXC.
- EXC (exactly one cycle):
  - flush[1:0]=1; all other inputs ignored. This drops the instruction fetched in the redirect cycle.
  - Next state RUN.
- mem_wait: stall=5'b01111, flush[4]=1 (bubble into WB).
- MULTI-busy:
  - Active when ex_multi_start=1 in RUN, or when state=MULTI and cnt!=0.
  - stall=5'b00111, flush[3]=1.
- br_redirect: flush[1:0]=1, fetch_redirect=1, fetch_pc=br_target. The issue logic guarantees the delay slot is already in EX or older.
- load_use: stall[1:0]=1, flush[2]=1.
- Idle cycle: stall=0, flush=0, fetch_redirect=0.
- Counter and state transitions:
  - RUN with ex_multi_start and no exc_req: cnt<=MC_LAT-1, next state MULTI. This applies even if mem_wait is also asserted.
  - MULTI: cnt decrements every cycle regardless of mem_wait, because the divider runs independently.
  - MULTI with cnt==0: not busy, next state RUN.
  - ex_multi_start while in MULTI or EXC is ignored.
- A lower-priority event masked by a higher one is not latched; its input is re-sampled next cycle. Redirect and hazard inputs remain asserted while their stage is held.

## Timing
- Reset values: state RUN, cnt 0, stall 0, flush 0, fetch_redirect 0, fetch_pc 0, multi_abort 0, perf_stall_cnt 0.
- Reset is taken mid-MULTI or mid-EXC without any abort pulse.
- Multi-cycle op started in cycle T: stall[2] is high T..T+MC_LAT-1 (MC_LAT cycles). is_ex advances at the edge ending T+MC_LAT-1.
- A mem_wait overlap inside the multi window does not extend the window. Stalls past it are due to mem_wait only.
- Exception at T: fetch_redirect at T. flush all at T, flush[1:0] at T+1. Normal operation from T+2.
- fetch_redirect is high for one cycle per winning redirect cycle.

## Configuration
- STALL_PERF_EN defined:
  - perf_stall_cnt increments in every cycle with stall[2]=1.
  - It wraps at 2^32 and is cleared only by rst.
- Undefined: perf_stall_cnt is tied to 0 and no counter register exists.

## Test plan
- load_use=1 for one cycle in RUN -> stall=5'b00011, flush=5'b00100. Next cycle (load_use=0) -> stall=0, flush=0.
- MC_LAT=4, ex_multi_start at T -> stall=5'b00111 and flush[3]=1 for T..T+3; T+4 stall=0; state returns to RUN.
- MULTI active with cnt=2, exc_req=1 -> flush=5'b11111, multi_abort=1, fetch_pc=32'hBFC0_0380. Next cycle flush=5'b00011. Cycle after that is idle.
- mem_wait and br_redirect together for 3 cycles, then mem_wait drops -> stall=5'b01111 and flush[4]=1 for 3 cycles, no fetch_redirect. Next cycle fetch_redirect=1 with fetch_pc=br_target, flush=5'b00011.
- exc_req and mem_wait in the same cycle -> exception path only: stall=0, flush=5'b11111.
- STALL_PERF_EN defined: 10 stall[2] cycles -> perf_stall_cnt=10. Assert rst -> 0 on the next edge.

Source files
------------

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
//
// Central stall/flush controller for the dual-issue pipeline. It drives the
// hold (stall) and clear (flush) controls of the five inter-stage registers
// from hazard, multi-cycle, cache-wait, branch-redirect and exception events.
// It owns the multi-cycle EX occupancy counter and the fetch-redirect request.
// Each pipeline register applies flush over stall.
//
// Event priority, highest first:
//   exc_req, mem_wait, multi-busy, br_redirect, load_use
//
// Parameters:
//   MC_LAT      cycles a multi-cycle EX op occupies EX (2..63)
//   EXC_VECTOR  fetch target on exception
//
// Ports:
//   clk             clock
//   rst             synchronous active-high reset
//   load_use        IS load-use hazard against EX
//   ex_multi_start  multi-cycle op entering EX this cycle
//   mem_wait        MEM waiting on D-cache/bus
//   br_redirect     EX resolved a mispredicted branch (level)
//   br_target       redirect PC, valid with br_redirect
//   exc_req         MEM commits an exception
//   stall[4:0]      per-register hold, bit0=if_id .. bit4=mem_wb
//   flush[4:0]      per-register clear, same bit order
//   fetch_redirect  one-cycle PC load request to IF
//   fetch_pc        PC for fetch_redirect (0 when no redirect)
//   multi_abort     pulse: kill the running multi-cycle unit
//   perf_stall_cnt  count of cycles with stall[2]=1
//
// Optional feature: define STALL_PERF_EN to build the stall-cycle counter.
// Without it perf_stall_cnt is tied to zero.
//
// Outputs are combinational from state, counter and inputs; they are forced
// to zero while rst is asserted so a reset cycle never emits an abort or
// redirect, even when it lands mid-MULTI or mid-EXC.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned MC_LAT     = 33,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use,
  input  logic        ex_multi_start,
  input  logic        mem_wait,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  output logic [4:0]  stall,
  output logic [4:0]  flush,
  output logic        fetch_redirect,
  output logic [31:0] fetch_pc,
  output logic        multi_abort,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MULTI = 2'd1,
    ST_EXC   = 2'd2
  } state_t;

  // Loaded on start; the start cycle itself is the first busy cycle.
  localparam logic [5:0] CNT_LOAD = 6'(MC_LAT - 1);

  state_t     state_r;
  state_t     state_nxt_s;
  logic [5:0] cnt_r;
  logic [5:0] cnt_nxt_s;
  logic       busy_s;

  // Multi-cycle occupancy: the start cycle in RUN, then every MULTI cycle
  // with a non-zero count.
  assign busy_s = ((state_r == ST_RUN) && ex_multi_start) ||
                  ((state_r == ST_MULTI) && (cnt_r != 6'd0));

  // State and occupancy-counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      cnt_r   <= 6'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and counter update. The divider runs independently, so the
  // count keeps moving even when mem_wait owns the stall outputs.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_RUN: begin
        if (exc_req) begin
          state_nxt_s = ST_EXC;
          cnt_nxt_s   = 6'd0;
        end else if (ex_multi_start) begin
          state_nxt_s = ST_MULTI;
          cnt_nxt_s   = CNT_LOAD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MULTI: begin
        if (exc_req) begin
          state_nxt_s = ST_EXC;
          cnt_nxt_s   = 6'd0;
        end else if (cnt_r == 6'd0) begin
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r - 6'd1;
        end
      end
      ST_EXC: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = 6'd0;
      end
      default: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = 6'd0;
      end
    endcase
  end

  // Output decode: only the highest-priority event drives stall/flush.
  always_comb begin
    stall          = 5'b00000;
    flush          = 5'b00000;
    fetch_redirect = 1'b0;
    fetch_pc       = 32'd0;
    multi_abort    = 1'b0;
    if (rst) begin
      stall = 5'b00000;
    end else begin
      case (state_r)
        ST_EXC: begin
          // Drop the instruction fetched during the redirect cycle.
          flush = 5'b00011;
        end
        ST_RUN, ST_MULTI: begin
          if (exc_req) begin
            flush          = 5'b11111;
            fetch_redirect = 1'b1;
            fetch_pc       = EXC_VECTOR;
            multi_abort    = (state_r == ST_MULTI) || ex_multi_start;
          end else if (mem_wait) begin
            stall = 5'b01111;
            flush = 5'b10000;
          end else if (busy_s) begin
            stall = 5'b00111;
            flush = 5'b01000;
          end else if (br_redirect) begin
            flush          = 5'b00011;
            fetch_redirect = 1'b1;
            fetch_pc       = br_target;
          end else if (load_use) begin
            stall = 5'b00011;
            flush = 5'b00100;
          end else begin
            stall = 5'b00000;
          end
        end
        default: begin
          stall = 5'b00000;
        end
      endcase
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_cnt_r;

  // Stall-cycle counter: counts cycles where is_ex is held; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_r <= 32'd0;
    end else if (stall[2]) begin
      perf_cnt_r <= perf_cnt_r + 32'd1;
    end else begin
      perf_cnt_r <= perf_cnt_r;
    end
  end

  assign perf_stall_cnt = perf_cnt_r;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
